// File: rtl/tie_bank_pkg.sv
// Shared types and legal-range constants for the tie bank sequencer.
// Also holds the helper that sizes the settle counter.
package tie_bank_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        OPEN   = 2'd1,
        LOCKED = 2'd2
    } tie_state_t;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 255;

    // Bits needed to hold n-1; never narrower than one bit so SETTLE=1 still elaborates.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tie_settle_cnt.sv
// Saturating post-reset hold counter: counts while enabled, stops at MAX-1.
// done is high whenever the count has reached MAX-1.
module tie_settle_cnt
    import tie_bank_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic ck,
    input  logic rst,
    input  logic en,
    output logic done
);

    localparam int             W    = cnt_w(MAX);
    localparam logic [W-1:0]   LAST = W'(MAX - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/tie_bank_seq.sv
// Tie-pattern register bank with post-reset hold, masked loads and a one-way lock.
// q only changes on a handshaken load while OPEN; LOCKED is left only through rst.
module tie_bank_seq
    import tie_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               SETTLE    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [WIDTH-1:0] ld_mask,
    input  logic             lock,
    output logic [WIDTH-1:0] q,
    output logic             settled,
    output logic             locked
);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("tie_bank_seq: WIDTH out of range");
    end
    if ((SETTLE < SETTLE_MIN) || (SETTLE > SETTLE_MAX)) begin : g_bad_settle
        $error("tie_bank_seq: SETTLE out of range");
    end

    tie_state_t state_q;
    tie_state_t state_d;
    logic       settle_done;
    logic       take;

    tie_settle_cnt #(
        .MAX (SETTLE)
    ) u_settle (
        .ck   (ck),
        .rst  (rst),
        .en   (state_q == HOLD),
        .done (settle_done)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (settle_done) state_d = OPEN;
            OPEN:    if (lock)        state_d = LOCKED;
            LOCKED:  state_d = LOCKED;
            default: state_d = HOLD;
        endcase
    end

    // Outputs decode state only, so ld_ready never depends on ld_valid.
    assign ld_ready = (state_q == OPEN);
    assign settled  = (state_q == OPEN) || (state_q == LOCKED);
    assign locked   = (state_q == LOCKED);
    assign take     = ld_valid && ld_ready;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (take) begin
            q <= (q & ~ld_mask) | (ld_data & ld_mask);
        end
    end

endmodule

// File: tb/tb_tie_bank_seq.sv
// Directed and randomized checks of tie_bank_seq against a cycle-count reference model.
// A second SETTLE=1 instance covers the minimum hold length.
module tb_tie_bank_seq;

    localparam int W = 8;
    localparam int S = 4;

    logic         ck = 1'b0;
    logic         rst, ld_valid, lock;
    logic [W-1:0] ld_data, ld_mask;
    logic         ld_ready, settled, locked;
    logic [W-1:0] q;

    logic         rst1, ld_valid1, lock1;
    logic [W-1:0] ld_data1, ld_mask1;
    logic         ld_ready1, settled1, locked1;
    logic [W-1:0] q1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: edges since rst release (saturating), lock flag, pattern.
    int           m_edges;
    bit           m_lock;
    logic [W-1:0] m_q;

    always #5 ck = ~ck;

    tie_bank_seq #(.WIDTH(W), .SETTLE(S), .RESET_VAL(8'hFF)) dut (
        .ck(ck), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_mask(ld_mask), .lock(lock),
        .q(q), .settled(settled), .locked(locked)
    );

    tie_bank_seq #(.WIDTH(W), .SETTLE(1), .RESET_VAL(8'hFF)) dut1 (
        .ck(ck), .rst(rst1), .ld_valid(ld_valid1), .ld_ready(ld_ready1),
        .ld_data(ld_data1), .ld_mask(ld_mask1), .lock(lock1),
        .q(q1), .settled(settled1), .locked(locked1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return !m_lock && (m_edges >= S);
    endfunction

    task automatic m_reset();
        m_edges = 0;
        m_lock  = 1'b0;
        m_q     = 8'hFF;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},        q,        m_q);
        check({tag, ".ld_ready"}, ld_ready, m_ready());
        check({tag, ".settled"},  settled,  m_edges >= S);
        check({tag, ".locked"},   locked,   m_lock);
    endtask

    // One rising edge: advance the model on the inputs held across it, then sample at +1.
    task automatic step();
        bit rdy;
        @(posedge ck);
        rdy = m_ready();
        if (rdy) begin
            if (ld_valid) m_q = (m_q & ~ld_mask) | (ld_data & ld_mask);
            if (lock) m_lock = 1'b1;
        end else if (!m_lock && m_edges < S) begin
            m_edges++;
        end
        #1;
    endtask

    // Called just after a step: pulse rst between edges and check outputs with no clock.
    task automatic async_rst(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, ".rst_q"},      q,        8'hFF);
        check({tag, ".rst_locked"}, locked,   1'b0);
        check({tag, ".rst_ready"},  ld_ready, 1'b0);
        check({tag, ".rst_settled"}, settled, 1'b0);
        #1 rst = 1'b0;
        m_reset();
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; lock = 1'b0; ld_data = '0; ld_mask = '0;
        rst1 = 1'b1; ld_valid1 = 1'b0; lock1 = 1'b0; ld_data1 = '0; ld_mask1 = '0;
        m_reset();

        repeat (2) @(posedge ck);
        #1;
        check("reset.q",        q,        8'hFF);
        check("reset.ld_ready", ld_ready, 1'b0);
        check("reset.settled",  settled,  1'b0);
        check("reset.locked",   locked,   1'b0);

        // Hold period with ld_valid high the whole time (zero-mask loads once open).
        #2 rst = 1'b0;
        m_reset();
        ld_valid = 1'b1; ld_data = 8'h00; ld_mask = 8'h00;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e <= 3) begin
                check($sformatf("hold.e%0d.q", e),     q,        8'hFF);
                check($sformatf("hold.e%0d.ready", e), ld_ready, 1'b0);
            end else if (e == 4) begin
                check("hold.e4.settled", settled,  1'b1);
                check("hold.e4.ready",   ld_ready, 1'b1);
            end
            check_model($sformatf("hold.e%0d", e));
        end

        // Back-to-back masked loads.
        ld_data = 8'hA5; ld_mask = 8'h0F;
        step();
        check("load1.q", q, 8'hF5);
        ld_data = 8'h00; ld_mask = 8'hF0;
        step();
        check("load2.q", q, 8'h05);
        ld_valid = 1'b0;
        step();
        check_model("idle");

        // Load and lock in the same cycle, then later loads ignored.
        ld_valid = 1'b1; ld_data = 8'h3C; ld_mask = 8'hFF; lock = 1'b1;
        step();
        check("lockld.q",      q,      8'h3C);
        check("lockld.locked", locked, 1'b1);
        lock = 1'b0; ld_data = 8'h00;
        for (int e = 0; e < 3; e++) begin
            step();
            check($sformatf("locked.e%0d.q", e),     q,        8'h3C);
            check($sformatf("locked.e%0d.ready", e), ld_ready, 1'b0);
        end

        // Asynchronous reset out of LOCKED with a load pending, then a full hold again.
        async_rst("lockrst");
        ld_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("rehold.e%0d.ready", e), ld_ready, e == 4);
            check_model($sformatf("rehold.e%0d", e));
        end

        // Randomized stream against the model.
        for (int c = 0; c < 1200; c++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 8'($urandom);
            ld_mask  = 8'($urandom);
            lock     = ($urandom_range(0, 63) == 0);
            step();
            check_model($sformatf("rnd%0d", c));
            if ($urandom_range(0, 149) == 0) async_rst($sformatf("rnd%0d", c));
        end
        ld_valid = 1'b0; lock = 1'b0;

        // SETTLE=1 instance: open after the first edge, load lands on the second.
        check("s1.reset.q", q1, 8'hFF);
        #2 rst1 = 1'b0;
        step();
        check("s1.e1.ready", ld_ready1, 1'b1);
        check("s1.e1.q",     q1,        8'hFF);
        ld_valid1 = 1'b1; ld_data1 = 8'h12; ld_mask1 = 8'hFF;
        step();
        check("s1.e2.q", q1, 8'h12);
        ld_valid1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
